exe_alu: RTL

EXE_ALU -- requirements
Module: exe_alu

---
 rtl/exe_alu.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/exe_alu.sv
// Execute-stage ALU for the 32-bit MIPS-style pipeline.
// Bitwise, shift, add/sub and compare results are combinational from the
// operands and the HI/LO registers. MULT/MULTU/MTHI/MTLO write HI/LO when the
// E-stage instruction commits. DIV/DIVU use a 32-iteration restoring divider
// that freezes the E stage through div_stall.
module exe_alu (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  alucontrol,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  sa,
    input  logic        valid_e,
    input  logic        flush_e,
    input  logic        stall_e,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow,
    output logic        div_stall
);

    // Operation encodings shared with aludec
    localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [7:0] EXE_ANDI_OP  = 8'b0101_1001;
    localparam logic [7:0] EXE_ORI_OP   = 8'b0101_1010;
    localparam logic [7:0] EXE_XORI_OP  = 8'b0101_1011;
    localparam logic [7:0] EXE_LUI_OP   = 8'b0101_1100;
    localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [7:0] EXE_SLLV_OP  = 8'b0000_0100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [7:0] EXE_SRLV_OP  = 8'b0000_0110;
    localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [7:0] EXE_SRAV_OP  = 8'b0000_0111;
    localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
    localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
    localparam logic [7:0] EXE_ADDI_OP  = 8'b0101_0101;
    localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] EXE_J_OP     = 8'b0100_1111;
    localparam logic [7:0] EXE_BEQ_OP   = 8'b0101_0001;
    localparam logic [7:0] EXE_LW_OP    = 8'b1110_0011;
    localparam logic [7:0] EXE_SW_OP    = 8'b1110_1011;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // Two's-complement negate when neg is set; used for |x| and sign fix-up
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        cond_neg = neg ? (32'h0 - v) : v;
    endfunction

    logic [31:0] hi_r;
    logic [31:0] lo_r;
    div_state_t  state_r;
    logic [5:0]  count_r;
    logic [31:0] quo_r;
    logic [31:0] rem_r;
    logic [31:0] dvs_r;
    logic        neg_q_r;
    logic        neg_rem_r;

    logic        we_s;
    logic [31:0] sum_s;
    logic [31:0] diff_s;
    logic [63:0] mul_signed_s;
    logic [63:0] mul_unsigned_s;
    logic        is_div_s;
    logic        div_signed_s;
    logic        div_start_s;
    logic [32:0] rem_shift_s;
    logic [32:0] trial_s;
    logic [31:0] rem_next_s;
    logic        q_bit_s;
    logic [31:0] quo_final_s;
    logic [31:0] rem_final_s;
    logic        div_write_s;

    assign we_s           = valid_e & ~flush_e & ~stall_e;
    assign sum_s          = a + b;
    assign diff_s         = a - b;
    assign mul_signed_s   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign mul_unsigned_s = {32'h0, a} * {32'h0, b};

    assign is_div_s     = (alucontrol == EXE_DIV_OP) || (alucontrol == EXE_DIVU_OP);
    assign div_signed_s = (alucontrol == EXE_DIV_OP);
    assign div_start_s  = (state_r == DIV_IDLE) && valid_e && !flush_e && is_div_s
                          && (b != 32'h0);
    assign div_stall    = div_start_s || (state_r == DIV_BUSY);

    assign rem_shift_s = {rem_r, quo_r[31]};
    assign trial_s     = rem_shift_s - {1'b0, dvs_r};
    assign quo_final_s = cond_neg(quo_r, neg_q_r);
    assign rem_final_s = cond_neg(rem_r, neg_rem_r);
    assign div_write_s = (state_r == DIV_DONE) && !flush_e && !stall_e;

    assign zero = (result == 32'h0);

    // Restoring step: keep the trial subtraction only when it did not borrow
    always_comb begin
        rem_next_s = rem_shift_s[31:0];
        q_bit_s    = 1'b0;
        if (!trial_s[32]) begin
            rem_next_s = trial_s[31:0];
            q_bit_s    = 1'b1;
        end else begin
            rem_next_s = rem_shift_s[31:0];
            q_bit_s    = 1'b0;
        end
    end

    // Combinational result and signed-overflow selection by operation
    always_comb begin
        result   = 32'h0;
        overflow = 1'b0;
        case (alucontrol)
            EXE_AND_OP, EXE_ANDI_OP: result = a & b;
            EXE_OR_OP,  EXE_ORI_OP:  result = a | b;
            EXE_XOR_OP, EXE_XORI_OP: result = a ^ b;
            EXE_NOR_OP:              result = ~(a | b);
            EXE_LUI_OP:              result = {b[15:0], 16'h0};
            EXE_SLL_OP:              result = b << sa;
            EXE_SRL_OP:              result = b >> sa;
            EXE_SRA_OP:              result = $unsigned($signed(b) >>> sa);
            EXE_SLLV_OP:             result = b << a[4:0];
            EXE_SRLV_OP:             result = b >> a[4:0];
            EXE_SRAV_OP:             result = $unsigned($signed(b) >>> a[4:0]);
            EXE_SLT_OP:              result = {31'h0, ($signed(a) < $signed(b))};
            EXE_ADD_OP, EXE_ADDI_OP: begin
                result   = sum_s;
                overflow = (a[31] == b[31]) && (sum_s[31] != a[31]);
            end
            EXE_LW_OP, EXE_SW_OP:    result = sum_s;
            EXE_SUB_OP: begin
                result   = diff_s;
                overflow = (a[31] == ~b[31]) && (diff_s[31] != a[31]);
            end
            EXE_BEQ_OP:              result = diff_s;
            EXE_MFHI_OP:             result = hi_r;
            EXE_MFLO_OP:             result = lo_r;
            default:                 result = 32'h0;
        endcase
    end

    // Divider FSM: latch magnitudes, iterate 32 quotient bits, wait to commit
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r   <= DIV_IDLE;
            count_r   <= 6'd0;
            quo_r     <= 32'h0;
            rem_r     <= 32'h0;
            dvs_r     <= 32'h0;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
        end else begin
            case (state_r)
                DIV_IDLE: begin
                    if (div_start_s) begin
                        quo_r     <= cond_neg(a, div_signed_s & a[31]);
                        dvs_r     <= cond_neg(b, div_signed_s & b[31]);
                        rem_r     <= 32'h0;
                        neg_q_r   <= div_signed_s & (a[31] ^ b[31]);
                        neg_rem_r <= div_signed_s & a[31];
                        count_r   <= 6'd0;
                        state_r   <= DIV_BUSY;
                    end else begin
                        state_r   <= DIV_IDLE;
                    end
                end
                DIV_BUSY: begin
                    if (flush_e) begin
                        count_r <= 6'd0;
                        state_r <= DIV_IDLE;
                    end else begin
                        quo_r   <= {quo_r[30:0], q_bit_s};
                        rem_r   <= rem_next_s;
                        count_r <= count_r + 6'd1;
                        if (count_r == 6'd31) begin
                            state_r <= DIV_DONE;
                        end else begin
                            state_r <= DIV_BUSY;
                        end
                    end
                end
                DIV_DONE: begin
                    if (flush_e || !stall_e) begin
                        count_r <= 6'd0;
                        state_r <= DIV_IDLE;
                    end else begin
                        state_r <= DIV_DONE;
                    end
                end
                default: begin
                    count_r <= 6'd0;
                    state_r <= DIV_IDLE;
                end
            endcase
        end
    end

    // HI/LO: divider commit, or committed MT*/MULT* instruction
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi_r <= 32'h0;
            lo_r <= 32'h0;
        end else if (div_write_s) begin
            lo_r <= quo_final_s;
            hi_r <= rem_final_s;
        end else if (we_s) begin
            case (alucontrol)
                EXE_MTHI_OP:  hi_r <= a;
                EXE_MTLO_OP:  lo_r <= a;
                EXE_MULT_OP:  {hi_r, lo_r} <= mul_signed_s;
                EXE_MULTU_OP: {hi_r, lo_r} <= mul_unsigned_s;
                default: begin
                    hi_r <= hi_r;
                    lo_r <= lo_r;
                end
            endcase
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

endmodule
